march_bist_engine: RTL and testbench

MARCH_BIST_ENGINE -- requirements
Module: march_bist_engine

---
 rtl/march_bist_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_march_bist_engine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/march_bist_engine.sv
// March C- memory BIST engine.
//
// Runs March C- (M0 up w0; M1 up r0,w1; M2 up r1,w0; M3 down r0,w1; M4 down r1,w0;
// M5 down r0) over a 2^A_WIDTH x WIDTH memory using a solid and/or checkerboard
// background. Each op takes one cycle, each read is followed by one compare cycle,
// and one NEXT_ELEM cycle separates elements, so one background is 15*DEPTH+6 cycles.
//
// Ports:
//   clk, rst (async active-low)       clock and reset
//   start, mode[1:0], stop_on_fail    test request, background select, abort on mismatch
//   mem_addr, mem_wdata, mem_wr,      memory interface; mem_rdata valid one cycle
//   mem_rd, mem_rdata                 after mem_rd
//   busy, done, fail, fail_count      test status
//   fail_addr, fail_exp, fail_act     first-fail log
//
// Optional feature: define BIST_FAIL_LOG_EN to capture the first mismatch into the
// fail log; otherwise the log outputs are tied to zero.
module march_bist_engine #(
  parameter int unsigned A_WIDTH   = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 stop_on_fail,
  output logic [A_WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 mem_wr,
  output logic                 mem_rd,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [CNT_WIDTH-1:0] fail_count,
  output logic [A_WIDTH-1:0]   fail_addr,
  output logic [WIDTH-1:0]     fail_exp,
  output logic [WIDTH-1:0]     fail_act
);

  typedef enum logic [2:0] {
    StIdle, StWrite, StRead, StCmp, StNextElem, StDone
  } state_e;

  localparam logic [A_WIDTH-1:0]   AddrLast  = '1;
  localparam logic [CNT_WIDTH-1:0] CntMax    = '1;
  // Checkerboard "0": bit0 = 1, alternating upward.
  localparam logic [WIDTH-1:0]     CbPattern = {(WIDTH / 2){2'b01}};
  localparam logic [2:0]           ElemLast  = 3'd5;

  state_e                 state_q, state_d;
  logic [2:0]             elem_q, elem_d;
  logic [A_WIDTH-1:0]     addr_q, addr_d;
  logic                   cb_q, cb_d;          // current background is checkerboard
  logic                   two_pass_q, two_pass_d;
  logic                   sof_q, sof_d;
  logic                   fail_q, fail_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]       bg;
  logic [WIDTH-1:0]       wr_data;
  logic [WIDTH-1:0]       exp_data;
  logic                   down;
  logic [A_WIDTH-1:0]     addr_end;
  logic [A_WIDTH-1:0]     addr_step;
  logic                   mismatch;
  logic                   accept;

  always_comb begin
    bg        = cb_q ? CbPattern : '0;
    // Write polarity is 1 in M1/M3, read polarity is 1 in M2/M4.
    wr_data   = bg ^ {WIDTH{elem_q[0]}};
    exp_data  = bg ^ {WIDTH{~elem_q[0]}};
    down      = (elem_q >= 3'd3);
    addr_end  = down ? '0 : AddrLast;
    addr_step = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
    mismatch  = (state_q == StCmp) && (mem_rdata != exp_data);
    accept    = start && ((state_q == StIdle) || (state_q == StDone));
  end

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    addr_d     = addr_q;
    cb_d       = cb_q;
    two_pass_d = two_pass_q;
    sof_d      = sof_q;
    fail_d     = fail_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d    = StWrite;
          elem_d     = 3'd0;
          addr_d     = '0;
          cb_d       = (mode == 2'b01);
          two_pass_d = mode[1];
          sof_d      = stop_on_fail;
          fail_d     = 1'b0;
          cnt_d      = '0;
        end
      end
      StWrite: begin
        if (addr_q == addr_end) begin
          state_d = StNextElem;
        end else begin
          addr_d  = addr_step;
          state_d = (elem_q == 3'd0) ? StWrite : StRead;
        end
      end
      StRead: state_d = StCmp;
      StCmp: begin
        if (mismatch) begin
          fail_d = 1'b1;
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        end
        if (mismatch && sof_q) begin
          state_d = StDone;
        end else if (elem_q == ElemLast) begin
          if (addr_q == addr_end) begin
            state_d = StNextElem;
          end else begin
            addr_d  = addr_step;
            state_d = StRead;
          end
        end else begin
          state_d = StWrite;
        end
      end
      StNextElem: begin
        if (elem_q == ElemLast) begin
          if (two_pass_q && !cb_q) begin
            cb_d    = 1'b1;
            elem_d  = 3'd0;
            addr_d  = '0;
            state_d = StWrite;
          end else begin
            state_d = StDone;
          end
        end else begin
          elem_d  = elem_q + 3'd1;
          // M3..M5 start at the top of memory.
          addr_d  = (elem_q >= 3'd2) ? AddrLast : '0;
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      elem_q     <= 3'd0;
      addr_q     <= '0;
      cb_q       <= 1'b0;
      two_pass_q <= 1'b0;
      sof_q      <= 1'b0;
      fail_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      addr_q     <= addr_d;
      cb_q       <= cb_d;
      two_pass_q <= two_pass_d;
      sof_q      <= sof_d;
      fail_q     <= fail_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef BIST_FAIL_LOG_EN
  logic [A_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [WIDTH-1:0]   fail_exp_q, fail_exp_d;
  logic [WIDTH-1:0]   fail_act_q, fail_act_d;

  always_comb begin
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
    if (accept) begin
      fail_addr_d = '0;
      fail_exp_d  = '0;
      fail_act_d  = '0;
    end else if (mismatch && !fail_q) begin
      fail_addr_d = addr_q;
      fail_exp_d  = exp_data;
      fail_act_d  = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else begin
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;
`else
  assign fail_addr = '0;
  assign fail_exp  = '0;
  assign fail_act  = '0;
`endif

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    mem_wr     = (state_q == StWrite);
    mem_rd     = (state_q == StRead);
    mem_addr   = addr_q;
    mem_wdata  = mem_wr ? wr_data : '0;
    busy       = (state_q != StIdle) && (state_q != StDone);
    done       = (state_q == StDone);
    fail       = fail_q;
    fail_count = cnt_q;
  end

endmodule

// File: tb/tb_march_bist_engine.sv
// Directed bench for march_bist_engine: a fault-injectable 16x4 memory on the main
// instance, and a second instance (CNT_WIDTH=2) on a memory that inverts every read.
module tb_march_bist_engine;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       stop_on_fail;

  logic [3:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_wr, mem_rd;
  logic       busy, done, fail;
  logic [7:0] fail_count;
  logic [3:0] fail_addr, fail_exp, fail_act;

  logic [3:0] mem_addr2, mem_wdata2, mem_rdata2;
  logic       mem_wr2, mem_rd2;
  logic       busy2, done2, fail2;
  logic [1:0] fail_count2;
  logic [3:0] fail_addr2, fail_exp2, fail_act2;

  int checks;
  int failures;

  logic       fault_en;
  logic [3:0] mem1 [16];
  logic [3:0] mem2 [16];
  int         wr_cnt, rd_cnt, wlog_n;
  logic [3:0] wlog [256];

  march_bist_engine #(.A_WIDTH(4), .WIDTH(4), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stop_on_fail(stop_on_fail),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .fail(fail),
    .fail_count(fail_count), .fail_addr(fail_addr), .fail_exp(fail_exp),
    .fail_act(fail_act)
  );

  march_bist_engine #(.A_WIDTH(4), .WIDTH(4), .CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stop_on_fail(stop_on_fail),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_wr(mem_wr2), .mem_rd(mem_rd2),
    .mem_rdata(mem_rdata2), .busy(busy2), .done(done2), .fail(fail2),
    .fail_count(fail_count2), .fail_addr(fail_addr2), .fail_exp(fail_exp2),
    .fail_act(fail_act2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models with registered read data; bit 2 of address 9 optionally stuck-at-1.
  always @(posedge clk) begin
    if (mem_wr) begin
      mem1[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      if (mem_addr == 4'd0) begin
        wlog[wlog_n[7:0]] <= mem_wdata;
        wlog_n <= wlog_n + 1;
      end
    end
    if (mem_rd) begin
      mem_rdata <= mem1[mem_addr] | ((fault_en && mem_addr == 4'd9) ? 4'h4 : 4'h0);
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_wr2) mem2[mem_addr2] <= mem_wdata2;
    if (mem_rd2) mem_rdata2 <= ~mem2[mem_addr2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on one edge, then count edges until done; optionally re-pulse start
  // at edge 'poke' while busy.
  task automatic run(input logic [1:0] m, input logic sof, input int poke,
                     output int n);
    mode = m;
    stop_on_fail = sof;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 600) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == poke);
    end
    start = 1'b0;
    if (n >= 600) check("done_timeout", 32'(n), 32'd0);
  endtask

  int n;
  int wr0, rd0, wb;

  initial begin
    checks = 0;
    failures = 0;
    wr_cnt = 0;
    rd_cnt = 0;
    wlog_n = 0;
    fault_en = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    mode = 2'b00;
    stop_on_fail = 1'b0;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_count", 32'(fail_count), 32'd0);
    check("rst_wr_rd", {30'd0, mem_wr, mem_rd}, 32'd0);
    check("rst_addr_wdata", {24'd0, mem_addr, mem_wdata}, 32'd0);
    check("rst_log", {20'd0, fail_addr, fail_exp, fail_act}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fault-free, solid background.
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    run(2'b00, 1'b0, -1, n);
    check("m00_cycles", 32'(n), 32'd246);
    check("m00_fail", 32'(fail), 32'd0);
    check("m00_count", 32'(fail_count), 32'd0);
    check("m00_wr_cnt", 32'(wr_cnt - wr0), 32'd80);
    check("m00_rd_cnt", 32'(rd_cnt - rd0), 32'd80);
    check("m00_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 check("done_held", 32'(done), 32'd1);

    // Solid then checkerboard.
    wb = wlog_n;
    run(2'b10, 1'b0, -1, n);
    check("m10_cycles", 32'(n), 32'd492);
    check("m10_fail", 32'(fail), 32'd0);
    check("m10_solid_w0", 32'(wlog[wb[7:0]]), 32'h0);
    check("m10_solid_w1", 32'(wlog[8'(wb + 1)]), 32'hF);
    check("m10_cb_w0", 32'(wlog[8'(wb + 5)]), 32'h5);
    check("m10_cb_w1", 32'(wlog[8'(wb + 6)]), 32'hA);

    // Stuck-at-1 on address 9 bit 2.
    fault_en = 1'b1;
    run(2'b00, 1'b0, -1, n);
    check("sa1_cycles", 32'(n), 32'd246);
    check("sa1_fail", 32'(fail), 32'd1);
    check("sa1_count", 32'(fail_count), 32'd3);
`ifdef BIST_FAIL_LOG_EN
    check("sa1_log_addr", 32'(fail_addr), 32'd9);
    check("sa1_log_exp", 32'(fail_exp), 32'h0);
    check("sa1_log_act", 32'(fail_act), 32'h4);
`else
    check("sa1_log_tied", {20'd0, fail_addr, fail_exp, fail_act}, 32'd0);
`endif

    // Same fault, abort on first mismatch (M1 CMP at address 9 is edge 45).
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    run(2'b00, 1'b1, -1, n);
    check("sof_cycles", 32'(n), 32'd46);
    check("sof_count", 32'(fail_count), 32'd1);
    check("sof_fail", 32'(fail), 32'd1);
    check("sof_wr_cnt", 32'(wr_cnt - wr0), 32'd25);
    check("sof_rd_cnt", 32'(rd_cnt - rd0), 32'd10);
    fault_en = 1'b0;

    // Reset asserted mid-M3 (edge 120 is an M3 write).
    mode = 2'b00;
    stop_on_fail = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (120) @(posedge clk);
    #1 check("m3_wr_active", 32'(mem_wr), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_wr_rd", {30'd0, mem_wr, mem_rd}, 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_count", 32'(fail_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run(2'b00, 1'b0, -1, n);
    check("post_rst_cycles", 32'(n), 32'd246);
    check("post_rst_fail", 32'(fail), 32'd0);

    // Saturation on the all-faulty instance; start pulsed while busy.
    run(2'b00, 1'b0, 100, n);
    check("busy_start_cycles", 32'(n), 32'd246);
    check("sat_done2", 32'(done2), 32'd1);
    check("sat_fail2", 32'(fail2), 32'd1);
    check("sat_count2", 32'(fail_count2), 32'd3);
    check("sat_main_clean", 32'(fail_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
